bp_be_fe_queue_rollback_fifo: RTL

Circular buffer between the front-end fetch stream and the back-end issue logic. It holds fetch/exception messages and delivers them in order to the issue stage. It keeps every issued entry until commit, so that a cache-miss replay can roll back and re-issue. It also discards un-issued entries on a flush.

---
 rtl/bp_be_fe_queue_rollback_fifo_pkg.sv | 15 +
 rtl/bp_be_fe_queue_rollback_fifo_mem.sv | 24 ++
 rtl/bp_be_fe_queue_rollback_fifo.sv | 89 ++++++++
 3 files changed

// File: rtl/bp_be_fe_queue_rollback_fifo_pkg.sv
// Shared configuration for the front-end -> back-end fetch queue.
// Holds the processor-level widths and the helper that sizes one queue message.
package bp_be_fe_queue_rollback_fifo_pkg;

  localparam int vaddr_width_gp               = 39;
  localparam int branch_metadata_fwd_width_gp = 24;
  localparam int instr_width_gp               = 32;
  localparam int fe_queue_els_gp              = 8;

  // One message: type bit, pc, instruction/exception payload, branch metadata.
  function automatic int fe_queue_width(input int vaddr_width, input int bmeta_width);
    return 1 + vaddr_width + instr_width_gp + bmeta_width;
  endfunction

endpackage

// File: rtl/bp_be_fe_queue_rollback_fifo_mem.sv
// Entry storage: one synchronous write port and one asynchronous read port.
module bp_be_fe_queue_rollback_fifo_mem #(
  parameter int width_p = 8,
  parameter int els_p   = 8
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [$clog2(els_p)-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [$clog2(els_p)-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  // Write the accepted entry into its slot.
  // NOTE: storage has no reset; slot validity is tracked entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_q[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_rollback_fifo.sv
// Fetch queue with speculative issue: entries stay resident from enqueue until
// commit (deq), so a replay can rewind the read pointer (roll) and re-issue.
// A flush (clr) drops everything not yet issued.
module bp_be_fe_queue_rollback_fifo
  import bp_be_fe_queue_rollback_fifo_pkg::*;
#(
  parameter  int vaddr_width_p               = vaddr_width_gp,
  parameter  int branch_metadata_fwd_width_p = branch_metadata_fwd_width_gp,
  parameter  int els_p                       = fe_queue_els_gp,
  localparam int width_lp     = fe_queue_width(vaddr_width_p, branch_metadata_fwd_width_p),
  localparam int ptr_width_lp = $clog2(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [width_lp-1:0] fe_queue_i,
  input  logic                fe_queue_v_i,
  output logic                fe_queue_ready_o,
  output logic [width_lp-1:0] fe_queue_o,
  output logic                fe_queue_v_o,
  input  logic                fe_queue_yumi_i,
  input  logic                fe_queue_clr_i,
  input  logic                fe_queue_roll_i,
  input  logic                fe_queue_deq_i,
  output logic                empty_o
);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  typedef logic [ptr_width_lp:0] ptr_t;

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t cptr_q, cptr_d;

  logic full;
  logic enq;

  // Full when write is exactly one lap ahead of commit.
  assign full = (wptr_q[ptr_width_lp] != cptr_q[ptr_width_lp])
             && (wptr_q[ptr_width_lp-1:0] == cptr_q[ptr_width_lp-1:0]);

  assign fe_queue_ready_o = ~full;
  assign fe_queue_v_o     = (rptr_q != wptr_q);
  assign empty_o          = (cptr_q == wptr_q);
  assign enq              = fe_queue_v_i & ~full;

  // Next pointers: commit first, then read (may rewind to the new commit),
  // then write (a flush collapses it onto the new read pointer).
  // NOTE: every _d is assigned on every path of this block, so no latch is inferred.
  always_comb begin
    cptr_d = cptr_q + ptr_t'(fe_queue_deq_i);
    rptr_d = fe_queue_roll_i ? cptr_d : rptr_q + ptr_t'(fe_queue_yumi_i);
    wptr_d = fe_queue_clr_i  ? rptr_d : wptr_q + ptr_t'(enq);
  end

  // Pointer registers; reset empties the queue whatever else is asserted.
  // NOTE: non-blocking updates make all three pointers advance from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  bp_be_fe_queue_rollback_fifo_mem #(
    .width_p (width_lp),
    .els_p   (els_p)
  ) u_mem (
    .clk_i    (clk_i),
    .w_v_i    (enq & ~fe_queue_clr_i),
    .w_addr_i (wptr_q[ptr_width_lp-1:0]),
    .w_data_i (fe_queue_i),
    .r_addr_i (rptr_q[ptr_width_lp-1:0]),
    .r_data_o (fe_queue_o)
  );

  // Retiring an entry that was never issued is a protocol error.
  deq_only_issued_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(fe_queue_deq_i && (cptr_q == rptr_q)));

  // Consuming with nothing presented is a protocol error.
  yumi_only_valid_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(fe_queue_yumi_i && !fe_queue_v_o));

endmodule
